// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the register file's single write port between the data-memory load
// path (highest priority) and the ALU result path. ALU writes that cannot be
// granted are held in a small in-order pending queue, so ALU write order is
// never reordered.
//
// Ports:
//   CLK, RESET            clock and synchronous active-high reset
//   ALU_REQ/ADDR/DATA     ALU write-back request
//   MEM_REQ/ADDR/DATA     load write-back request (always wins)
//   RD1ADDR, RD2ADDR      register-file read addresses for the hazard check
//   WRITE/INADDRESS/IN    registered register-file write port
//   STALL                 registered, high while the queue is full
//   HAZARD                combinational, a read hits a not-yet-committed write
//   OVERFLOW              sticky, an ALU request was dropped
module regfile_wb_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ALU_REQ,
    input  logic [2:0] ALU_ADDR,
    input  logic [7:0] ALU_DATA,
    input  logic       MEM_REQ,
    input  logic [2:0] MEM_ADDR,
    input  logic [7:0] MEM_DATA,
    input  logic [2:0] RD1ADDR,
    input  logic [2:0] RD2ADDR,
    output logic       WRITE,
    output logic [2:0] INADDRESS,
    output logic [7:0] IN,
    output logic       STALL,
    output logic       HAZARD,
    output logic       OVERFLOW
);

    // Queue occupancy doubles as the state encoding (value == entry count).
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } qstate_t;

    qstate_t    state_q, state_d;
    logic [2:0] qaddr_q [DEPTH];
    logic [2:0] qaddr_d [DEPTH];
    logic [7:0] qdata_q [DEPTH];
    logic [7:0] qdata_d [DEPTH];
    logic       write_q, write_d;
    logic [2:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic       stall_q, stall_d;
    logic       ovf_q, ovf_d;

    logic [1:0] cnt;
    logic [1:0] cnt_after_pop;
    logic [1:0] cnt_next;
    logic       pop;
    logic       alu_direct;
    logic       push;

    assign cnt = state_q;

    always_comb begin
        // Queue head is granted whenever it exists and the load path is idle.
        pop        = (state_q != EMPTY) && !MEM_REQ;
        alu_direct = ALU_REQ && !MEM_REQ && (state_q == EMPTY);
        cnt_after_pop = cnt - {1'b0, pop};
        // Space is judged after this cycle's pop, so push+pop works when full.
        push       = ALU_REQ && !alu_direct && (cnt_after_pop < 2'(DEPTH));
        cnt_next   = cnt_after_pop + {1'b0, push};

        state_d  = qstate_t'(cnt_next);
        stall_d  = (cnt_next == 2'(DEPTH));
        ovf_d    = ovf_q || (ALU_REQ && !alu_direct && !push);

        // Shift toward the head on pop, then append behind remaining entries.
        for (int i = 0; i < DEPTH; i++) begin
            qaddr_d[i] = qaddr_q[i];
            qdata_d[i] = qdata_q[i];
        end
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                qaddr_d[i] = qaddr_q[i + 1];
                qdata_d[i] = qdata_q[i + 1];
            end
        end
        if (push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (2'(i) == cnt_after_pop) begin
                    qaddr_d[i] = ALU_ADDR;
                    qdata_d[i] = ALU_DATA;
                end
            end
        end

        // Fixed priority: load, queue head, direct ALU. Hold port when idle.
        write_d = 1'b1;
        addr_d  = addr_q;
        data_d  = data_q;
        if (MEM_REQ) begin
            addr_d = MEM_ADDR;
            data_d = MEM_DATA;
        end else if (state_q != EMPTY) begin
            addr_d = qaddr_q[0];
            data_d = qdata_q[0];
        end else if (ALU_REQ) begin
            addr_d = ALU_ADDR;
            data_d = ALU_DATA;
        end else begin
            write_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= EMPTY;
            write_q <= 1'b0;
            addr_q  <= 3'd0;
            data_q  <= 8'd0;
            stall_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            stall_q <= stall_d;
            ovf_q   <= ovf_d;
        end
    end

    // Entry payloads need no reset; occupancy alone decides validity.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < DEPTH; i++) begin
            qaddr_q[i] <= qaddr_d[i];
            qdata_q[i] <= qdata_d[i];
        end
    end

    // A write on the port is still uncommitted until the next edge, so it
    // counts as pending alongside the queued entries.
    always_comb begin
        HAZARD = write_q && ((addr_q == RD1ADDR) || (addr_q == RD2ADDR));
        for (int i = 0; i < DEPTH; i++) begin
            if ((2'(i) < cnt) &&
                ((qaddr_q[i] == RD1ADDR) || (qaddr_q[i] == RD2ADDR))) begin
                HAZARD = 1'b1;
            end
        end
    end

    assign WRITE     = write_q;
    assign INADDRESS = addr_q;
    assign IN        = data_q;
    assign STALL     = stall_q;
    assign OVERFLOW  = ovf_q;

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter for the 8x8-bit register file. It shares the file's single write port (WRITE/INADDRESS/IN) between two requesters: the ALU result path and the data-memory load path. ALU writes that lose arbitration are held in a 2-entry in-order pending queue. A hazard flag marks reads of registers whose writes are still pending, so the control unit can stall.

## Interface
Parameters:
- DEPTH, 2, ALU pending-queue entries; fixed at 2 for this revision.

Ports:
- CLK  input  1  clock; all state updates on posedge, #1 after the edge.
- RESET  input  1  synchronous, active-high reset, sampled on posedge CLK.
- ALU_REQ  input  1  ALU write-back request, valid for the sampled cycle.
- ALU_ADDR  input  3  ALU destination register.
- ALU_DATA  input  8  ALU result.
- MEM_REQ  input  1  load write-back request, valid for the sampled cycle.
- MEM_ADDR  input  3  load destination register.
- MEM_DATA  input  8  loaded byte.
- RD1ADDR  input  3  register-file read port 1 address, for the hazard check.
- RD2ADDR  input  3  register-file read port 2 address, for the hazard check.
- WRITE  output  1  register-file write enable, registered.
- INADDRESS  output  3  register-file write address, registered.
- IN  output  8  register-file write data, registered.
- STALL  output  1  registered; high while the queue holds 2 entries.
- HAZARD  output  1  combinational; RD1ADDR or RD2ADDR matches a valid queue entry.
- OVERFLOW  output  1  sticky error flag; set when an ALU request is dropped.

## Operation
- Arbitration at each posedge uses the sampled inputs. Fixed priority:
  1. MEM_REQ.
  2. Queue head.
  3. Direct ALU_REQ.
- Only one write is granted per cycle.
- Direct ALU grant requires queue empty and MEM_REQ low.
- If the queue is non-empty, a new ALU_REQ is pushed behind the existing entries, never bypassed, so ALU write order is preserved.
- ALU_REQ not granted directly is pushed when the queue has space after this cycle's pop.
  - Push and pop in the same cycle are allowed, including when the queue is full.
- ALU_REQ arriving with the queue full, MEM_REQ high and no pop: the request is dropped and OVERFLOW is set. OVERFLOW is cleared only by RESET.
- Granted source: registered into INADDRESS/IN with WRITE=1 for exactly one cycle.
- No grant: WRITE=0; INADDRESS/IN hold their previous values.
- Queue states:
  - EMPTY: count 0.
  - ONE: count 1.
  - FULL: count 2.
  - Transitions: count += push − pop.
- STALL equals (next count == 2), registered. The control unit must hold ALU_REQ low while STALL=1; the arbiter tolerates violations per the overflow rule.
- HAZARD compares both read addresses against every valid queue entry. The entry currently driven on INADDRESS/IN with WRITE=1 also counts until the register file commits it.
- MEM_REQ and a queued ALU write to the same address are not merged; both are written in grant order.
- Reset values: WRITE=0, INADDRESS=0, IN=0, STALL=0, HAZARD=0, OVERFLOW=0, queue EMPTY. Requests sampled in the RESET cycle are discarded.

## Timing
- Latency:
  - Request sampled at edge N.
  - WRITE/INADDRESS/IN valid at N+#1.
  - Register file commits at edge N+1.
  - Readable on OUT1/OUT2 at N+1+#1+#2.
- A queued ALU write waits one extra cycle per preceding MEM grant or queue entry.
- Back-to-back grants produce WRITE high on consecutive cycles with changing INADDRESS/IN.
- Reset mid-operation: the pending queue is lost, and WRITE drops at the RESET edge +#1. Any write already presented is committed or not according to the register file's own RESET priority; the register file clears in the same cycle.
- HAZARD settles within the same cycle that RD1ADDR/RD2ADDR change. There is no edge dependency except queue updates at #1.

## Test plan
- Reset, then ALU_REQ=1 with addr 3, data 0x2A for one cycle -> WRITE=1, INADDRESS=3, IN=0x2A for one cycle; reg3 reads 0x2A afterward; STALL=0.
- MEM_REQ (addr 1, 0x11) and ALU_REQ (addr 2, 0x22) in the same cycle -> write reg1=0x11, then reg2=0x22 on the next cycle; HAZARD=1 for RD1ADDR=2 during the wait.
- MEM_REQ held high for 3 cycles with ALU_REQ on cycles 1–2 (addr 4 0x44, addr 5 0x55) -> STALL=1 after the second push; after MEM_REQ drops, writes are 4=0x44 then 5=0x55, in order.
- Queue full, MEM_REQ high, and a third ALU_REQ (addr 6, 0x66) -> request dropped, OVERFLOW=1 sticky; reg6 unchanged (0x00).
- Queue holds 2 entries, then RESET for one cycle -> queue empty, WRITE=0, STALL=0, OVERFLOW=0, all registers 0x00; no later write from the old entries.
- Queue non-empty and MEM idle, with a new ALU_REQ in the same cycle as a pop -> simultaneous push/pop: count unchanged, order preserved, no OVERFLOW.
